attex_bus_ctrl: RTL and testbench
=================================

ATTEX_BUS_CTRL -- requirements
Module: attex_bus_ctrl

Interface
REQ-001 Parameter FIXED_WAIT, default 2, wait cycles for CDIC and NVRAM accesses (1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in clk cycles (1..255), used only with ATTEX_BUS_TIMEOUT_EN.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 as  in  1  CPU address strobe, active high.
REQ-006 uds, lds  in  1 each  CPU upper/lower data strobes, active high.
REQ-007 write_strobe  in  1  CPU write cycle when high.
REQ-008 addr  in  23  CPU word address [23:1].
REQ-009 mcd212_ack  in  1  MCD212 ready, level, active high.
REQ-010 slave_dtack  in  1  raw slave-controller DTACK line; ready is a 0->1 edge.
REQ-011 cs_mcd212, cs_cdic, cs_slave, cs_nvram  out  1 each  registered one-hot chip selects.
REQ-012 bus_ack  out  1  one-cycle acknowledge pulse to CPU.
REQ-013 bus_err  out  1  one-cycle bus error pulse to CPU.
REQ-014 nvram_we  out  1  one-cycle NVRAM write enable, coincident with bus_ack.
REQ-015 slave_start  out  1  one-cycle pulse on entry to a slave access (drives slave IRQ cooldown).

Function
REQ-016 States: IDLE, WAIT, ACK, ERR, HOLD; one-hot or encoded at implementer choice.
REQ-017 IDLE: when as && (uds||lds), decode addr (byte address = {addr,0}) in the same cycle and register the result.
REQ-018 Decode priority: bus-error region (0x600000-0xCFFFFF or >=0xF00000) -> ERR; 0x30xxxx -> cdic; 0x31xxxx -> slave; 0x32xxxx -> nvram; 0x000000-0x27FFFF or 0x400000-0x7FFFFF -> mcd212; any other -> ERR.
REQ-019 Non-error decode -> WAIT with exactly one cs_* high from the next cycle until leaving HOLD.
REQ-020 WAIT cdic/nvram: down-counter loaded with FIXED_WAIT; ACK when counter reaches 0 (latency as-to-bus_ack = FIXED_WAIT+1 cycles).
REQ-021 WAIT mcd212: ACK the cycle after mcd212_ack sampled high.
REQ-022 WAIT slave: ACK the cycle after slave_dtack sampled high while its registered copy was low; a line already high on entry does not acknowledge.
REQ-023 ACK: bus_ack high one cycle; nvram_we high in that cycle iff cs_nvram && write_strobe && uds; then HOLD.
REQ-024 ERR: bus_err high one cycle, no cs_* asserted, then HOLD.
REQ-025 HOLD: chip selects held; return to IDLE when as low; new cycle not accepted until IDLE.
REQ-026 as falling during WAIT: abort to IDLE next cycle, cs_* cleared, no bus_ack, no bus_err.
REQ-027 bus_ack and bus_err never high in the same cycle.
REQ-028 slave_start high the cycle cs_slave first rises.

Reset
REQ-029 reset_n low: state IDLE, all outputs 0, counters 0, slave_dtack registered copy 1, effective immediately and asynchronously, including mid-cycle.
REQ-030 After reset_n release, first access accepted no earlier than the following rising edge.

Configuration
REQ-031 Macro ATTEX_BUS_TIMEOUT_EN defined: 8-bit watchdog cleared on WAIT entry, increments in WAIT; reaching TIMEOUT_CYCLES -> ERR (bus_err) instead of waiting further.
REQ-032 Macro undefined: no watchdog logic; WAIT persists until acknowledge or as falls.

Verification
REQ-033 Read addr 0x300000, FIXED_WAIT=2 -> cs_cdic next cycle, bus_ack exactly 3 cycles after as, single pulse.
REQ-034 Write 0x320010 with uds=1 -> nvram_we and bus_ack high same single cycle; with uds=0 lds=1 -> bus_ack, nvram_we stays 0.
REQ-035 Access 0x310000 with slave_dtack held 1 -> no ack; drive 0 then 1 -> bus_ack one cycle after rise; slave_start pulses once at entry.
REQ-036 Access 0x600000 and 0xF00000 -> bus_err one pulse, all cs_* 0, bus_ack 0.
REQ-037 With ATTEX_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, mcd212 access at 0x000100 with mcd212_ack=0 -> bus_err 16 cycles after WAIT entry; without macro no bus_err after 1000 cycles.
REQ-038 reset_n pulsed low during WAIT of mcd212 access -> all outputs 0 immediately, IDLE; next access completes normally.

Source files
------------

// File: rtl/attex_bus_ctrl.sv
// CPU bus controller: decodes CPU cycles to MCD212/CDIC/slave/NVRAM, sequences wait states, ack and bus error.
// Optional watchdog enabled by defining ATTEX_BUS_TIMEOUT_EN.
module attex_bus_ctrl #(
  parameter int FIXED_WAIT     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [22:0] addr,
  input  logic        mcd212_ack,
  input  logic        slave_dtack,
  output logic        cs_mcd212,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_nvram,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        nvram_we,
  output logic        slave_start
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_ERR, S_HOLD} state_t;
  typedef enum logic [2:0] {T_ERR, T_MCD, T_CDIC, T_SLAVE, T_NVRAM} tgt_t;

  if (FIXED_WAIT < 1 || FIXED_WAIT > 15) begin : g_bad_wait
    $error("FIXED_WAIT out of range 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..255");
  end

  // Error windows are tested first so they shadow the upper MCD212 range.
  function automatic tgt_t decode(input logic [23:0] ba);
    if ((ba >= 24'h600000 && ba <= 24'hCFFFFF) || ba >= 24'hF00000) return T_ERR;
    if (ba[23:16] == 8'h30) return T_CDIC;
    if (ba[23:16] == 8'h31) return T_SLAVE;
    if (ba[23:16] == 8'h32) return T_NVRAM;
    if (ba <= 24'h27FFFF || (ba >= 24'h400000 && ba <= 24'h7FFFFF)) return T_MCD;
    return T_ERR;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cs_q, cs_d;          // {mcd212, cdic, slave, nvram}
  logic [3:0]  cnt_q, cnt_d;
  logic        dtack_q, dtack_d;
  logic        bus_ack_q, bus_ack_d;
  logic        bus_err_q, bus_err_d;
  logic        we_q, we_d;
  logic        sstart_q, sstart_d;
`ifdef ATTEX_BUS_TIMEOUT_EN
  logic [7:0]  wd_q, wd_d;
`endif

  tgt_t        tgt;
  logic        ack_hit;

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    cnt_d     = cnt_q;
    dtack_d   = slave_dtack;
    bus_ack_d = 1'b0;
    bus_err_d = 1'b0;
    we_d      = 1'b0;
    sstart_d  = 1'b0;
`ifdef ATTEX_BUS_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    tgt     = decode({addr, 1'b0});
    // Slave ready is a fresh 0->1 edge, so a line stuck high never acks.
    ack_hit = (cs_q[3] && mcd212_ack) ||
              ((cs_q[2] || cs_q[0]) && cnt_q == 4'd0) ||
              (cs_q[1] && slave_dtack && !dtack_q);

    unique case (state_q)
      S_IDLE: begin
        if (as && (uds || lds)) begin
          if (tgt == T_ERR) begin
            state_d   = S_ERR;
            bus_err_d = 1'b1;
            cs_d      = 4'b0000;
          end else begin
            state_d  = S_WAIT;
            cnt_d    = 4'(FIXED_WAIT);
            sstart_d = (tgt == T_SLAVE);
`ifdef ATTEX_BUS_TIMEOUT_EN
            wd_d     = 8'd0;
`endif
            unique case (tgt)
              T_MCD:   cs_d = 4'b1000;
              T_CDIC:  cs_d = 4'b0100;
              T_SLAVE: cs_d = 4'b0010;
              default: cs_d = 4'b0001;
            endcase
          end
        end
      end
      S_WAIT: begin
        if (!as) begin
          state_d = S_IDLE;
          cs_d    = 4'b0000;
        end else if (ack_hit) begin
          state_d   = S_ACK;
          bus_ack_d = 1'b1;
          we_d      = cs_q[0] && write_strobe && uds;
`ifdef ATTEX_BUS_TIMEOUT_EN
        end else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_ERR;
          bus_err_d = 1'b1;
          cs_d      = 4'b0000;
`endif
        end else begin
          cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
`ifdef ATTEX_BUS_TIMEOUT_EN
          wd_d  = wd_q + 8'd1;
`endif
        end
      end
      S_ACK, S_ERR: state_d = S_HOLD;
      S_HOLD: begin
        if (!as) begin
          state_d = S_IDLE;
          cs_d    = 4'b0000;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cs_q      <= 4'b0000;
      cnt_q     <= 4'd0;
      dtack_q   <= 1'b1;
      bus_ack_q <= 1'b0;
      bus_err_q <= 1'b0;
      we_q      <= 1'b0;
      sstart_q  <= 1'b0;
`ifdef ATTEX_BUS_TIMEOUT_EN
      wd_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      cnt_q     <= cnt_d;
      dtack_q   <= dtack_d;
      bus_ack_q <= bus_ack_d;
      bus_err_q <= bus_err_d;
      we_q      <= we_d;
      sstart_q  <= sstart_d;
`ifdef ATTEX_BUS_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign {cs_mcd212, cs_cdic, cs_slave, cs_nvram} = cs_q;
  assign bus_ack     = bus_ack_q;
  assign bus_err     = bus_err_q;
  assign nvram_we    = we_q;
  assign slave_start = sstart_q;

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// Scoreboard bench for attex_bus_ctrl: directed accesses push expected ack/err events, a monitor pops and checks.
module tb_attex_bus_ctrl;

  localparam int FW = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        as = 1'b0, uds = 1'b0, lds = 1'b0, write_strobe = 1'b0;
  logic [22:0] addr = '0;
  logic        mcd212_ack = 1'b0, slave_dtack = 1'b1;
  logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram;
  logic        bus_ack, bus_err, nvram_we, slave_start;

  attex_bus_ctrl #(.FIXED_WAIT(FW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .as(as), .uds(uds), .lds(lds),
    .write_strobe(write_strobe), .addr(addr), .mcd212_ack(mcd212_ack),
    .slave_dtack(slave_dtack), .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic),
    .cs_slave(cs_slave), .cs_nvram(cs_nvram), .bus_ack(bus_ack),
    .bus_err(bus_err), .nvram_we(nvram_we), .slave_start(slave_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [3:0] cs;
    bit         we;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   ev_cnt = 0;
  int   sstart_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  wire [3:0] cs_v = {cs_mcd212, cs_cdic, cs_slave, cs_nvram};
  wire [7:0] outs = {cs_v, bus_ack, bus_err, nvram_we, slave_start};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (slave_start) sstart_cnt++;
      if (bus_ack || bus_err) begin
        ev_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event ack=%0b err=%0b cs=%b cyc=%0d", bus_ack, bus_err, cs_v, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("kind", int'({bus_ack, bus_err}), e.err ? 1 : 2);
          chk("cs_at_event", int'(cs_v), int'(e.cs));
          chk("nvram_we", int'(nvram_we), int'(e.we));
          chk("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_event(input int start, input string nm);
    for (int i = 0; i < 300 && ev_cnt == start; i++) @(negedge clk);
    if (ev_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_event expected=event", nm);
    end
  endtask

  task automatic end_cycle();
    as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_cs", int'(cs_v), 0);
  endtask

  // lat: cycles from the driving negedge to the negedge where the event is visible
  task automatic access(input logic [23:0] ba, input bit wr, input bit u, input bit l,
                        input bit err, input logic [3:0] cs, input bit we, input int lat);
    int c, start;
    exp_t e;
    @(negedge clk);
    start = ev_cnt;
    addr = ba[23:1]; as = 1'b1; uds = u; lds = l; write_strobe = wr;
    c = cyc;
    e.err = err; e.cs = err ? 4'b0000 : cs; e.we = we; e.cyc = c + lat;
    exp_q.push_back(e);
    @(negedge clk);
    chk("cs_next_cycle", int'(cs_v), err ? 0 : int'(cs));
    wait_event(start, "access");
    end_cycle();
  endtask

  typedef struct {
    logic [23:0] ba;
    bit          err;
    logic [3:0]  cs;
  } dec_t;

  dec_t dec_tab[15] = '{
    '{24'h000000, 1'b0, 4'b1000}, '{24'h27FFFE, 1'b0, 4'b1000},
    '{24'h280000, 1'b1, 4'b0000}, '{24'h2FFFFE, 1'b1, 4'b0000},
    '{24'h30FFFE, 1'b0, 4'b0100}, '{24'h32ABCE, 1'b0, 4'b0001},
    '{24'h330000, 1'b1, 4'b0000}, '{24'h3FFFFE, 1'b1, 4'b0000},
    '{24'h400000, 1'b0, 4'b1000}, '{24'h5FFFFE, 1'b0, 4'b1000},
    '{24'h600000, 1'b1, 4'b0000}, '{24'hCFFFFE, 1'b1, 4'b0000},
    '{24'hD00000, 1'b1, 4'b0000}, '{24'hEFFFFE, 1'b1, 4'b0000},
    '{24'hF00000, 1'b1, 4'b0000}
  };

  initial begin
    int start, lat;
    logic [23:0] ba;
    #3;
    chk("reset_outs", int'(outs), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", int'(outs), 0);

    // CDIC read: ack FIXED_WAIT+1 edges after the accepting edge
    access(24'h300000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, FW + 2);
    // NVRAM writes: upper strobe enables write, lower-only does not
    access(24'h320010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, FW + 2);
    access(24'h320010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, FW + 2);
    // NVRAM read with uds: no write enable
    access(24'h320010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, FW + 2);

    // Decode table, MCD212 ready already high so it acks on the first WAIT edge
    mcd212_ack = 1'b1;
    foreach (dec_tab[i]) begin
      lat = dec_tab[i].err ? 1 : (dec_tab[i].cs == 4'b1000 ? 2 : FW + 2);
      access(dec_tab[i].ba, 1'b0, 1'b1, 1'b1, dec_tab[i].err, dec_tab[i].cs, 1'b0, lat);
    end

    // Slave: line held high does not ack; a 0->1 edge acks one cycle later
    sstart_cnt = 0;
    slave_dtack = 1'b1;
    @(negedge clk);
    start = ev_cnt;
    ba = 24'h310000;
    addr = ba[23:1]; as = 1'b1; uds = 1'b1; lds = 1'b0;
    @(negedge clk);
    chk("slave_cs", int'(cs_v), 4'b0010);
    chk("slave_start_pulse", int'(slave_start), 1);
    repeat (6) @(negedge clk);
    chk("slave_no_ack_high", ev_cnt - start, 0);
    slave_dtack = 1'b0;
    @(negedge clk);
    chk("slave_no_ack_low", ev_cnt - start, 0);
    begin
      exp_t e;
      slave_dtack = 1'b1;
      e.err = 1'b0; e.cs = 4'b0010; e.we = 1'b0; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    wait_event(start, "slave");
    end_cycle();
    chk("slave_start_count", sstart_cnt, 1);

    // Abort: as falls during WAIT, no ack or err, chip select cleared
    mcd212_ack = 1'b0;
    @(negedge clk);
    start = ev_cnt;
    ba = 24'h000100;
    addr = ba[23:1]; as = 1'b1; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    chk("abort_cs_wait", int'(cs_v), 4'b1000);
    @(negedge clk);
    as = 1'b0; uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    chk("abort_cs_cleared", int'(cs_v), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_event", ev_cnt - start, 0);

`ifdef ATTEX_BUS_TIMEOUT_EN
    // Watchdog: bus_err TIMEOUT_CYCLES edges after WAIT entry
    access(24'h000100, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, TO + 1);
`else
    // No watchdog: MCD212 access waits indefinitely
    @(negedge clk);
    start = ev_cnt;
    ba = 24'h000100;
    addr = ba[23:1]; as = 1'b1; uds = 1'b1; lds = 1'b1;
    repeat (1000) @(negedge clk);
    chk("no_timeout_events", ev_cnt - start, 0);
    chk("no_timeout_cs", int'(cs_v), 4'b1000);
    end_cycle();
`endif

    // Asynchronous reset during an MCD212 WAIT
    @(negedge clk);
    ba = 24'h000200;
    addr = ba[23:1]; as = 1'b1; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    chk("pre_reset_cs", int'(cs_v), 4'b1000);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outs", int'(outs), 0);
    as = 1'b0; uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_reset_outs", int'(outs), 0);
    mcd212_ack = 1'b1;
    access(24'h000200, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 2);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
